// File: rtl/ospi_ctrl_pkg.sv
// Shared definitions for the OSPI flash sequencer: op encodings, FSM states, default widths.
package ospi_ctrl_pkg;

   localparam int OSPI_ADDR_W = 8;
   localparam int OSPI_DATA_W = 8;

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_ERASE = 2'd2;
   localparam logic [1:0] OP_RSVD  = 2'd3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SETUP,
      ST_W_WAIT,
      ST_W_STB,
      ST_W_VFY,
      ST_W_VCAP,
      ST_E_ISSUE,
      ST_R_ISSUE,
      ST_R_CAP,
      ST_R_WAIT,
      ST_HOLD,
      ST_DONE
   } state_t;

endpackage

// File: rtl/ospi_flash_ctrl.sv
// Host-side burst sequencer driving CS framing and one-hot per-byte strobes into an OSPI flash.
// Define OSPI_WR_VERIFY_EN to read back and compare every written byte (sticky err per burst).
module ospi_flash_ctrl
   import ospi_ctrl_pkg::*;
#(
   parameter int ADDR_W   = OSPI_ADDR_W,
   parameter int DATA_W   = OSPI_DATA_W,
   parameter int LEN_W    = 8,
   parameter int CS_SETUP = 1,
   parameter int CS_HOLD  = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              done,
   output logic              err,
   output logic              busy,
   output logic              fl_cs_n,
   output logic              fl_write_enable,
   output logic              fl_read_enable,
   output logic              fl_erase_enable,
   output logic [ADDR_W-1:0] fl_address,
   output logic [DATA_W-1:0] fl_data_in,
   input  logic [DATA_W-1:0] fl_data_out
);

   localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

   state_t            r_state;
   logic [1:0]        r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_rem;
   logic [7:0]        r_cnt;
   logic              r_err_acc;
   logic              r_req_ready, r_wr_ready, r_rd_valid, r_done, r_err, r_busy;
   logic              r_cs_n, r_we, r_re, r_ee;
   logic [ADDR_W-1:0] r_fl_addr;
   logic [DATA_W-1:0] r_fl_din, r_rd_data;

   logic              w_last;
   logic [ADDR_W-1:0] w_addr_nxt;

   assign w_last     = (r_rem == '0);
   assign w_addr_nxt = r_addr + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_READ;
         r_addr      <= '0;
         r_rem       <= '0;
         r_cnt       <= '0;
         r_err_acc   <= 1'b0;
         r_req_ready <= 1'b1;
         r_wr_ready  <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_cs_n      <= 1'b1;
         r_we        <= 1'b0;
         r_re        <= 1'b0;
         r_ee        <= 1'b0;
         r_fl_addr   <= '0;
         r_fl_din    <= '0;
      end else begin
         // Strobes and done are single-cycle pulses unless re-armed below.
         r_we   <= 1'b0;
         r_re   <= 1'b0;
         r_ee   <= 1'b0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_op        <= req_op;
                  r_addr      <= req_addr;
                  r_rem       <= req_len;
                  r_err_acc   <= 1'b0;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (req_op == OP_RSVD) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= ST_SETUP;
                     r_cs_n  <= 1'b0;
                     r_cnt   <= '0;
                  end
               end
            end
            ST_SETUP: begin
               if (r_cnt == SETUP_LAST) begin
                  case (r_op)
                     OP_WRITE: begin
                        r_state    <= ST_W_WAIT;
                        r_wr_ready <= 1'b1;
                     end
                     OP_ERASE: begin
                        r_state   <= ST_E_ISSUE;
                        r_ee      <= 1'b1;
                        r_fl_addr <= r_addr;
                     end
                     default: begin
                        r_state   <= ST_R_ISSUE;
                        r_re      <= 1'b1;
                        r_fl_addr <= r_addr;
                     end
                  endcase
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_W_WAIT: begin
               if (wr_valid) begin
                  r_wr_ready <= 1'b0;
                  r_we       <= 1'b1;
                  r_fl_addr  <= r_addr;
                  r_fl_din   <= wr_data;
                  r_state    <= ST_W_STB;
               end
            end
`ifdef OSPI_WR_VERIFY_EN
            ST_W_STB: begin
               r_re    <= 1'b1;
               r_state <= ST_W_VFY;
            end
            ST_W_VFY: r_state <= ST_W_VCAP;
            ST_W_VCAP: begin
               if (fl_data_out != r_fl_din) r_err_acc <= 1'b1;
               r_addr <= w_addr_nxt;
               r_rem  <= r_rem - 1'b1;
               if (w_last) begin
                  r_state <= ST_HOLD;
                  r_cnt   <= '0;
               end else begin
                  r_state    <= ST_W_WAIT;
                  r_wr_ready <= 1'b1;
               end
            end
`else
            ST_W_STB: begin
               r_addr <= w_addr_nxt;
               r_rem  <= r_rem - 1'b1;
               if (w_last) begin
                  r_state <= ST_HOLD;
                  r_cnt   <= '0;
               end else begin
                  r_state    <= ST_W_WAIT;
                  r_wr_ready <= 1'b1;
               end
            end
`endif
            ST_E_ISSUE: begin
               r_addr <= w_addr_nxt;
               r_rem  <= r_rem - 1'b1;
               if (w_last) begin
                  r_state <= ST_HOLD;
                  r_cnt   <= '0;
               end else begin
                  r_ee      <= 1'b1;
                  r_fl_addr <= w_addr_nxt;
               end
            end
            ST_R_ISSUE: r_state <= ST_R_CAP;
            ST_R_CAP: begin
               r_rd_data  <= fl_data_out;
               r_rd_valid <= 1'b1;
               r_state    <= ST_R_WAIT;
            end
            ST_R_WAIT: begin
               if (rd_ready) begin
                  r_rd_valid <= 1'b0;
                  r_addr     <= w_addr_nxt;
                  r_rem      <= r_rem - 1'b1;
                  if (w_last) begin
                     r_state <= ST_HOLD;
                     r_cnt   <= '0;
                  end else begin
                     r_state   <= ST_R_ISSUE;
                     r_re      <= 1'b1;
                     r_fl_addr <= w_addr_nxt;
                  end
               end
            end
            ST_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_cs_n  <= 1'b1;
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_err   <= r_err_acc;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_state     <= ST_IDLE;
               r_busy      <= 1'b0;
               r_req_ready <= 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready       = r_req_ready;
   assign wr_ready        = r_wr_ready;
   assign rd_valid        = r_rd_valid;
   assign rd_data         = r_rd_data;
   assign done            = r_done;
   assign err             = r_err;
   assign busy            = r_busy;
   assign fl_cs_n         = r_cs_n;
   assign fl_write_enable = r_we;
   assign fl_read_enable  = r_re;
   assign fl_erase_enable = r_ee;
   assign fl_address      = r_fl_addr;
   assign fl_data_in      = r_fl_din;

endmodule

// File: tb/tb_ospi_flash_ctrl.sv
// Self-checking bench: ospi_flash_ctrl paired with a small behavioural flash, read-byte scoreboard.
module tb_ospi_flash_ctrl;
   import ospi_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_op = 2'd0;
   logic [7:0] req_addr = 8'd0;
   logic [7:0] req_len = 8'd0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] wr_data = 8'd0;
   logic       rd_valid;
   logic       rd_ready = 1'b1;
   logic [7:0] rd_data;
   logic       done, err, busy;
   logic       fl_cs_n, fl_write_enable, fl_read_enable, fl_erase_enable;
   logic [7:0] fl_address, fl_data_in;
   logic [7:0] fl_data_out = 8'd0;

   logic       force_zero = 1'b0;
   logic [7:0] mem [256];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         rd_stb = 0;
   logic [7:0] sb[$];
   logic [7:0] wq[$];
   logic [7:0] er_q[$];

   ospi_flash_ctrl #(.ADDR_W(8), .DATA_W(8), .LEN_W(8), .CS_SETUP(1), .CS_HOLD(1)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_len(req_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .done(done), .err(err), .busy(busy),
      .fl_cs_n(fl_cs_n), .fl_write_enable(fl_write_enable),
      .fl_read_enable(fl_read_enable), .fl_erase_enable(fl_erase_enable),
      .fl_address(fl_address), .fl_data_in(fl_data_in), .fl_data_out(fl_data_out)
   );

   always #5 clk = ~clk;

   // Flash model: registered read data, erase writes 0xFF.
   always @(posedge clk) begin
      if (!fl_cs_n && fl_write_enable) mem[fl_address] <= fl_data_in;
      if (!fl_cs_n && fl_erase_enable) mem[fl_address] <= 8'hFF;
      if (!fl_cs_n && fl_read_enable)  fl_data_out <= force_zero ? 8'h00 : mem[fl_address];
   end

   // One clock: score handshakes about to complete, then sample after the negedge.
   task automatic cyc();
      logic [7:0] exp;
      if (rd_valid && rd_ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL rd_unexpected: got %h, required no byte", rd_data);
         end else begin
            exp = sb.pop_front();
            if (rd_data !== exp) begin
               n_bad++;
               $display("FAIL rd_data: got %h, required %h", rd_data, exp);
            end
         end
      end
      if (wr_valid && wr_ready && reset_n) void'(wq.pop_front());
      @(negedge clk);
      #1;
      wr_valid = (wq.size() != 0);
      wr_data  = (wq.size() != 0) ? wq[0] : 8'h00;
      if (fl_read_enable) rd_stb++;
      if (fl_erase_enable) er_q.push_back(fl_address);
      n_cmp++;
      if ((int'(fl_write_enable) + int'(fl_read_enable) + int'(fl_erase_enable) > 1) ||
          ((fl_write_enable | fl_read_enable | fl_erase_enable) && fl_cs_n)) begin
         n_bad++;
         $display("FAIL strobe_excl: got we/re/ee/cs_n %b%b%b%b, required one-hot with cs_n=0",
                  fl_write_enable, fl_read_enable, fl_erase_enable, fl_cs_n);
      end
   endtask

   task automatic do_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] l);
      bit acc = 0;
      req_valid = 1'b1; req_op = op; req_addr = a; req_len = l;
      for (int i = 0; i < 50 && !acc; i++) begin
         acc = req_ready;
         cyc();
      end
      req_valid = 1'b0;
      n_cmp++;
      if (!acc) begin
         n_bad++;
         $display("FAIL req_accept: got no accept in 50 cycles, required req_ready");
      end
   endtask

   task automatic wait_done(input int lim, output bit got, output logic e);
      got = 0; e = 1'b0;
      for (int i = 0; i < lim && !got; i++) begin
         cyc();
         if (done) begin got = 1; e = err; end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      cyc(); cyc();
      n_cmp++;
      if ({fl_cs_n, fl_write_enable, fl_read_enable, fl_erase_enable, rd_valid,
           done, err, busy, req_ready, wr_ready} !== 10'b1000_0000_10) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b, required 1000000010",
                  {fl_cs_n, fl_write_enable, fl_read_enable, fl_erase_enable, rd_valid,
                   done, err, busy, req_ready, wr_ready});
      end
      n_cmp++;
      if ({fl_address, fl_data_in, rd_data} !== 24'h0) begin
         n_bad++;
         $display("FAIL reset_data: got %h, required 000000", {fl_address, fl_data_in, rd_data});
      end
      reset_n = 1'b1;
      cyc(); cyc();
   endtask

   task automatic test_reset_mid();
      int nwe = 0;
      int ndone = 0;
      for (int i = 0; i < 8; i++) wq.push_back(8'hC0 + 8'(i));
      do_req(OP_WRITE, 8'h40, 8'd7);
      for (int i = 0; i < 100 && nwe < 3; i++) begin
         cyc();
         if (fl_write_enable) nwe++;
      end
      n_cmp++;
      if (fl_cs_n !== 1'b0 || nwe != 3) begin
         n_bad++;
         $display("FAIL mid_burst: got cs_n=%b strobes=%0d, required cs_n=0 strobes=3", fl_cs_n, nwe);
      end
      reset_n = 1'b0;
      cyc();
      n_cmp++;
      if ({fl_cs_n, fl_write_enable, fl_read_enable, fl_erase_enable, busy, done} !== 6'b100000) begin
         n_bad++;
         $display("FAIL reset_abort: got %b, required 100000",
                  {fl_cs_n, fl_write_enable, fl_read_enable, fl_erase_enable, busy, done});
      end
      reset_n = 1'b1;
      wq.delete();
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (done) ndone++;
      end
      n_cmp++;
      if (ndone != 0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_no_done: got done=%0d ready=%b, required 0 and 1", ndone, req_ready);
      end
   endtask

   task automatic test_write_read();
      bit got; logic e;
      for (int i = 0; i < 4; i++) wq.push_back(8'hA0 + 8'(i));
      do_req(OP_WRITE, 8'h10, 8'd3);
      n_cmp++;
      if ({busy, req_ready, fl_cs_n} !== 3'b100) begin
         n_bad++;
         $display("FAIL wr_setup: got busy/ready/cs_n %b, required 100", {busy, req_ready, fl_cs_n});
      end
      wait_done(200, got, e);
      n_cmp++;
      if (!got || e !== 1'b0) begin
         n_bad++;
         $display("FAIL wr_done: got done=%0d err=%b, required 1 0", got, e);
      end
      cyc();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL done_pulse: got done=%b busy=%b, required 0 0", done, busy);
      end
      for (int i = 0; i < 4; i++) sb.push_back(8'hA0 + 8'(i));
      do_req(OP_READ, 8'h10, 8'd3);
      wait_done(200, got, e);
      n_cmp++;
      if (!got || e !== 1'b0 || sb.size() != 0) begin
         n_bad++;
         $display("FAIL rd_done: got done=%0d err=%b left=%0d, required 1 0 0", got, e, sb.size());
      end
   endtask

   task automatic test_stall();
      bit got; logic e;
      int base;
      base = rd_stb;
      rd_ready = 1'b0;
      sb.push_back(8'hA0); sb.push_back(8'hA1);
      do_req(OP_READ, 8'h10, 8'd1);
      for (int i = 0; i < 20 && !rd_valid; i++) cyc();
      n_cmp++;
      if (rd_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL stall_valid: got rd_valid=%b, required 1", rd_valid);
      end
      for (int i = 0; i < 5; i++) begin
         cyc();
         n_cmp++;
         if ({rd_valid, rd_data, fl_cs_n} !== {1'b1, 8'hA0, 1'b0}) begin
            n_bad++;
            $display("FAIL stall_hold: got valid=%b data=%h cs_n=%b, required 1 a0 0",
                     rd_valid, rd_data, fl_cs_n);
         end
      end
      n_cmp++;
      if (rd_stb - base != 1) begin
         n_bad++;
         $display("FAIL stall_strobes: got %0d, required 1", rd_stb - base);
      end
      rd_ready = 1'b1;
      wait_done(100, got, e);
      n_cmp++;
      if (!got || rd_stb - base != 2 || sb.size() != 0) begin
         n_bad++;
         $display("FAIL stall_done: got done=%0d strobes=%0d left=%0d, required 1 2 0",
                  got, rd_stb - base, sb.size());
      end
   endtask

   task automatic test_erase();
      bit got; logic e;
      wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33); wq.push_back(8'h44);
      do_req(OP_WRITE, 8'hFE, 8'd3);
      wait_done(200, got, e);
      er_q.delete();
      do_req(OP_ERASE, 8'hFE, 8'd3);
      wait_done(100, got, e);
      n_cmp++;
      if (!got || e !== 1'b0 || er_q.size() != 4) begin
         n_bad++;
         $display("FAIL erase_done: got done=%0d err=%b strobes=%0d, required 1 0 4", got, e, er_q.size());
      end else begin
         n_cmp++;
         if ({er_q[0], er_q[1], er_q[2], er_q[3]} !== 32'hFEFF0001) begin
            n_bad++;
            $display("FAIL erase_wrap: got %h%h%h%h, required feff0001", er_q[0], er_q[1], er_q[2], er_q[3]);
         end
      end
      for (int i = 0; i < 4; i++) sb.push_back(8'hFF);
      do_req(OP_READ, 8'hFE, 8'd3);
      wait_done(200, got, e);
      n_cmp++;
      if (!got || sb.size() != 0) begin
         n_bad++;
         $display("FAIL erase_readback: got done=%0d left=%0d, required 1 0", got, sb.size());
      end
      er_q.delete();
      do_req(OP_ERASE, 8'h80, 8'hFF);
      wait_done(400, got, e);
      n_cmp++;
      if (!got || er_q.size() != 256) begin
         n_bad++;
         $display("FAIL erase_full: got done=%0d strobes=%0d, required 1 256", got, er_q.size());
      end else begin
         n_cmp++;
         if ({er_q[0], er_q[127], er_q[128], er_q[255]} !== 32'h80FF007F) begin
            n_bad++;
            $display("FAIL erase_full_wrap: got %h%h%h%h, required 80ff007f",
                     er_q[0], er_q[127], er_q[128], er_q[255]);
         end
      end
   endtask

   task automatic test_rsvd();
      do_req(OP_RSVD, 8'h00, 8'd0);
      n_cmp++;
      if ({done, err, fl_cs_n, busy} !== 4'b1111) begin
         n_bad++;
         $display("FAIL rsvd_done: got done/err/cs_n/busy %b, required 1111", {done, err, fl_cs_n, busy});
      end
      cyc();
      n_cmp++;
      if ({done, fl_cs_n, req_ready, busy} !== 4'b0110) begin
         n_bad++;
         $display("FAIL rsvd_after: got done/cs_n/ready/busy %b, required 0110",
                  {done, fl_cs_n, req_ready, busy});
      end
   endtask

   task automatic test_verify();
      bit got; logic e; logic exp_err;
`ifdef OSPI_WR_VERIFY_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      force_zero = 1'b1;
      wq.push_back(8'h5A);
      do_req(OP_WRITE, 8'h30, 8'd0);
      wait_done(100, got, e);
      n_cmp++;
      if (!got || e !== exp_err) begin
         n_bad++;
         $display("FAIL verify_err: got done=%0d err=%b, required 1 %b", got, e, exp_err);
      end
      force_zero = 1'b0;
   endtask

   initial begin
      #2;
      test_reset();
      test_reset_mid();
      test_write_read();
      test_stall();
      test_erase();
      test_rsvd();
      test_verify();
      cyc(); cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
